register_tree_sched: RTL

Multi-client scheduler that shares one register_tree priority queue (max-heap, root on o_data) among N_CLIENTS requesters. Arbitrates enqueue/dequeue/replace requests round-robin and issues them as one-cycle i_wrt/i_read strobes. Enforces the queue's settle time after each operation and returns the popped root (or an error) to the granted client. Sits between client logic and the register_tree instance.

---
 rtl/register_tree_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/register_tree_sched.sv
// register_tree_sched: round-robin front end sharing one register_tree max-heap.
// Define REGISTER_TREE_SCHED_STATS_EN to add issued/rejected op counters.
module register_tree_sched #(
    parameter int N_CLIENTS  = 4,
    parameter int QUEUE_SIZE = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ENQ_WAIT   = $clog2(QUEUE_SIZE) + 3,
    parameter int DEQ_WAIT   = 3
) (
    input  logic                             CLK,
    input  logic                             RSTn,
    input  logic [N_CLIENTS-1:0]             i_req_valid,
    input  logic [2*N_CLIENTS-1:0]           i_req_op,
    input  logic [DATA_WIDTH*N_CLIENTS-1:0]  i_req_data,
    output logic [N_CLIENTS-1:0]             o_req_ready,
    output logic                             o_rsp_valid,
    output logic [$clog2(N_CLIENTS)-1:0]     o_rsp_id,
    output logic [DATA_WIDTH-1:0]            o_rsp_data,
    output logic                             o_rsp_err,
    output logic                             o_pq_wrt,
    output logic                             o_pq_read,
    output logic [DATA_WIDTH-1:0]            o_pq_data,
    input  logic                             i_pq_full,
    input  logic                             i_pq_empty,
    input  logic [DATA_WIDTH-1:0]            i_pq_data
`ifdef REGISTER_TREE_SCHED_STATS_EN
    ,
    output logic [31:0]                      o_stat_issued,
    output logic [31:0]                      o_stat_rejected
`endif
);

    localparam int IW   = $clog2(N_CLIENTS);
    localparam int MAXW = (ENQ_WAIT > DEQ_WAIT) ? ENQ_WAIT : DEQ_WAIT;
    localparam int CW   = $clog2(MAXW + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;

    logic [1:0]            state;
    logic [IW-1:0]         last_grant;
    logic [CW-1:0]         cnt;
    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] key_q;
    logic [DATA_WIDTH-1:0] root_q;
    logic [IW-1:0]         id_q;
    logic                  err_q;

    logic [N_CLIENTS-1:0]  upper;
    logic [N_CLIENTS-1:0]  sel_vec;
    logic [IW-1:0]         grant_id;
    logic                  grant_hit;
    logic                  accept;
    logic [1:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_key;
    logic                  sel_err;
    logic                  is_enq;
    logic                  is_deq;
    logic                  is_rep;

    // Clients above the last grant win first; otherwise wrap to the lowest.
    always_comb begin
        upper = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            upper[k] = i_req_valid[k] && (IW'(k) > last_grant);
        end
    end

    always_comb begin
        sel_vec  = (|upper) ? upper : i_req_valid;
        grant_id = '0;
        for (int k = N_CLIENTS - 1; k >= 0; k--) begin
            if (sel_vec[k]) begin
                grant_id = IW'(k);
            end
        end
        grant_hit = |i_req_valid;
    end

    assign accept      = RSTn && (state == IDLE) && grant_hit;
    assign o_req_ready = accept ? (N_CLIENTS'(1) << grant_id) : '0;

    always_comb begin
        sel_op  = '0;
        sel_key = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (grant_id == IW'(k)) begin
                sel_op  = i_req_op[2*k +: 2];
                sel_key = i_req_data[DATA_WIDTH*k +: DATA_WIDTH];
            end
        end
    end

    assign is_enq = (sel_op == OP_ENQ);
    assign is_deq = (sel_op == OP_DEQ);
    assign is_rep = (sel_op == OP_REP);

    always_comb begin
        sel_err = 1'b1;
        unique case (1'b1)
            is_enq:         sel_err = i_pq_full;
            is_deq, is_rep: sel_err = i_pq_empty;
            default:        sel_err = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= IDLE;
            last_grant <= IW'(N_CLIENTS - 1);
            cnt        <= '0;
            op_q       <= '0;
            key_q      <= '0;
            root_q     <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= sel_op;
                        key_q      <= sel_key;
                        root_q     <= i_pq_data;
                        id_q       <= grant_id;
                        err_q      <= sel_err;
                        last_grant <= grant_id;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (err_q) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= (op_q == OP_ENQ) ? CW'(ENQ_WAIT)
                                                  : CW'(DEQ_WAIT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic issue;
    logic go;

    assign issue = (state == ISSUE);
    assign go    = issue && !err_q;

    assign o_rsp_valid = issue;
    assign o_rsp_id    = issue ? id_q : '0;
    assign o_rsp_err   = issue && err_q;
    assign o_rsp_data  = (go && op_q != OP_ENQ) ? root_q : '0;
    assign o_pq_wrt    = go && (op_q == OP_ENQ || op_q == OP_REP);
    assign o_pq_read   = go && (op_q == OP_DEQ || op_q == OP_REP);
    assign o_pq_data   = (go && op_q != OP_DEQ) ? key_q : '0;

`ifdef REGISTER_TREE_SCHED_STATS_EN
    logic [31:0] issued_q;
    logic [31:0] rejected_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            issued_q   <= '0;
            rejected_q <= '0;
        end else if (issue) begin
            if (err_q) begin
                if (rejected_q != '1) begin
                    rejected_q <= rejected_q + 32'd1;
                end
            end else if (issued_q != '1) begin
                issued_q <= issued_q + 32'd1;
            end
        end
    end

    assign o_stat_issued   = issued_q;
    assign o_stat_rejected = rejected_q;
`endif

endmodule
